// File: rtl/rvvi_stream_ctrl.sv
// rvvi_stream_ctrl
// Buffers compressed RVVI trace packets in a small FIFO. Each packet goes out
// on a valid/ready word stream as one header word and then a variable number
// of data words; how many depends on the packet's CSR count. A stall request
// back to the core keeps packets from being lost while Enable is high.
//
// State table
//   state  | meaning
//   S_IDLE | no transfer; when the FIFO is non-empty, latch the head's word count
//   S_HDR  | present the header word {seq, 8'h00, nwords}
//   S_DATA | present data word idx of the head, LS word first; pop on the last one
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   Enable, Valid, Rvvi   packet input from the bridge
//   TxData/TxValid/TxLast stream output, TxReady stream back-pressure
//   RvviStall             stall request to the core
//   Overflow              sticky drop flag, cleared by ClearOverflow
module rvvi_stream_ctrl #(
    parameter int XLEN      = 64,
    parameter int MAX_CSRS  = 5,
    parameter int PKT_BITS  = 72 + 5*XLEN + MAX_CSRS*(XLEN+16),
    parameter int WORD_BITS = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Enable,
    input  logic                 Valid,
    input  logic [PKT_BITS-1:0]  Rvvi,
    output logic [WORD_BITS-1:0] TxData,
    output logic                 TxValid,
    output logic                 TxLast,
    input  logic                 TxReady,
    output logic                 RvviStall,
    output logic                 Overflow,
    input  logic                 ClearOverflow
);

    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = PW + 1;
    localparam int NW_MAX   = (PKT_BITS + WORD_BITS - 1) / WORD_BITS;
    localparam int PAD_BITS = NW_MAX * WORD_BITS;
    localparam int WSH      = $clog2(WORD_BITS);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_HIGH = CW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [PKT_BITS-1:0] mem_q [DEPTH];

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     state_q, state_d;
    logic [15:0]    nwords_q, nwords_d;
    logic [15:0]    idx_q, idx_d;
    logic [7:0]     seq_q, seq_d;
    logic           ovf_q, ovf_d;

    logic                wr_en, drop, pop;
    logic [PKT_BITS-1:0] head;
    logic [PAD_BITS-1:0] head_pad;
    logic [11:0]         csr_raw;
    logic [31:0]         csr_sat, pkt_bits;
    logic [15:0]         nwords_head;
    logic [WORD_BITS-1:0] hdr_word, data_word;

    // Packet length of the FIFO head; the divide by WORD_BITS is a shift.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        head_pad = PAD_BITS'(head);
        csr_raw  = head[XLEN+179:XLEN+168];
        csr_sat  = (32'(csr_raw) > 32'(MAX_CSRS)) ? 32'(MAX_CSRS) : 32'(csr_raw);
        pkt_bits = 32'(72 + 5*XLEN) + csr_sat * 32'(XLEN + 16);
        nwords_head = 16'((pkt_bits + 32'(WORD_BITS - 1)) >> WSH);
        hdr_word  = WORD_BITS'({seq_q, 8'h00, nwords_q});
        data_word = WORD_BITS'(head_pad >> (32'(idx_q) * WORD_BITS));
    end

    // Writes never hit the entry being read: a write needs count < DEPTH.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= Rvvi;
        end
    end

    always_comb begin
        state_d  = state_q;
        nwords_d = nwords_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        pop      = 1'b0;
        TxValid  = 1'b0;
        TxLast   = 1'b0;
        TxData   = '0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    nwords_d = nwords_head;
                    idx_d    = '0;
                    state_d  = S_HDR;
                end
            end
            S_HDR: begin
                TxValid = 1'b1;
                TxData  = hdr_word;
                if (TxReady) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                TxValid = 1'b1;
                TxData  = data_word;
                TxLast  = (idx_q == nwords_q - 16'd1);
                if (TxReady) begin
                    if (TxLast) begin
                        pop     = 1'b1;
                        seq_d   = seq_q + 8'd1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en    = Valid & Enable & (count_q != CNT_FULL);
        drop     = Valid & Enable & (count_q == CNT_FULL);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ClearOverflow) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            nwords_q <= '0;
            idx_q    <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            nwords_q <= nwords_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            ovf_q    <= ovf_d;
        end
    end

    assign RvviStall = Enable & (count_q >= CNT_HIGH);
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_rvvi_stream_ctrl.sv
module tb_rvvi_stream_ctrl;

    localparam int PKT_BITS = 792;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                Enable = 1'b0;
    logic                Valid = 1'b0;
    logic [PKT_BITS-1:0] Rvvi = '0;
    logic [31:0]         TxData;
    logic                TxValid;
    logic                TxLast;
    logic                TxReady = 1'b0;
    logic                RvviStall;
    logic                Overflow;
    logic                ClearOverflow = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_q[$];
    logic        expl_q[$];
    logic [7:0]  exp_seq = 8'd0;
    int          rx_cnt = 0;
    logic [31:0] last_word = '0;
    logic [799:0] last_w, p5, p_a;

    rvvi_stream_ctrl dut (
        .clk(clk), .reset(reset), .Enable(Enable), .Valid(Valid), .Rvvi(Rvvi),
        .TxData(TxData), .TxValid(TxValid), .TxLast(TxLast), .TxReady(TxReady),
        .RvviStall(RvviStall), .Overflow(Overflow), .ClearOverflow(ClearOverflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Hand-computed word counts for XLEN=64, WORD_BITS=32.
    function automatic logic [15:0] nw_of(input logic [11:0] csr);
        case (csr)
            12'd0:   return 16'd13;
            12'd1:   return 16'd15;
            12'd2:   return 16'd18;
            12'd3:   return 16'd20;
            12'd4:   return 16'd23;
            default: return 16'd25;
        endcase
    endfunction

    task automatic push_exp(input logic [799:0] w, input logic [11:0] csr);
        logic [15:0] nw;
        nw = nw_of(csr);
        exp_q.push_back({exp_seq, 8'h00, nw});
        expl_q.push_back(1'b0);
        for (int i = 0; i < int'(nw); i++) begin
            exp_q.push_back(w[i*32 +: 32]);
            expl_q.push_back(i == int'(nw) - 1);
        end
        exp_seq = exp_seq + 8'd1;
    endtask

    // Call away from the rising edge; returns 1 time unit after the capture edge.
    task automatic send_pkt(input logic [11:0] csr, input bit accept);
        logic [799:0] w;
        for (int i = 0; i < 25; i++) w[i*32 +: 32] = $urandom;
        w[799:792] = '0;
        w[243:232] = csr;
        last_w = w;
        Rvvi   = w[791:0];
        Valid  = 1'b1;
        if (accept) push_exp(w, csr);
        @(posedge clk);
        #1;
        Valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !TxValid) break;
        end
        check_eq("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Stream monitor: a handshake seen at the falling edge completes on the next rising edge.
    initial begin
        bit          hold_prev;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [31:0] w;
        logic        l;
        hold_prev = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check_eq("hold_valid", 64'(TxValid), 64'd1);
                    check_eq("hold_data", 64'(TxData), 64'(prev_data));
                    check_eq("hold_last", 64'(TxLast), 64'(prev_last));
                end
                hold_prev = TxValid && !TxReady;
                prev_data = TxData;
                prev_last = TxLast;
                if (TxValid && TxReady) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_word", 64'(exp_q.size()), 64'd1);
                    end else begin
                        w = exp_q.pop_front();
                        l = expl_q.pop_front();
                        check_eq("word", 64'(TxData), 64'(w));
                        check_eq("last", 64'(TxLast), 64'(l));
                        rx_cnt++;
                        if (TxLast) begin
                            rx_cnt = 0;
                            last_word = TxData;
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit found;

        #12;
        check_eq("rst_txvalid", 64'(TxValid), 64'd0);
        check_eq("rst_txlast", 64'(TxLast), 64'd0);
        check_eq("rst_stall", 64'(RvviStall), 64'd0);
        check_eq("rst_ovf", 64'(Overflow), 64'd0);
        check_eq("rst_count", 64'(dut.count_q), 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        Enable  = 1'b1;
        TxReady = 1'b1;

        // CsrCnt=0: 13 data words, header latency, then seq advances.
        send_pkt(12'd0, 1'b1);
        @(negedge clk);
        check_eq("bubble_valid", 64'(TxValid), 64'd0);
        @(negedge clk);
        check_eq("hdr_valid", 64'(TxValid), 64'd1);
        check_eq("hdr0", 64'(TxData), 64'h0000000D);
        wait_drain(100);
        send_pkt(12'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_eq("hdr1", 64'(TxData), 64'h0100000D);
        wait_drain(100);

        // CsrCnt=1, 5, and a saturated count.
        send_pkt(12'd1, 1'b1);
        send_pkt(12'd5, 1'b1);
        p5 = last_w;
        wait_drain(300);
        check_eq("csr5_last_word", 64'(last_word), 64'({8'h00, p5[791:768]}));
        send_pkt(12'hFFF, 1'b1);
        wait_drain(100);

        // Back-pressure, stall, overflow.
        TxReady = 1'b0;
        send_pkt(12'd0, 1'b1);
        send_pkt(12'd1, 1'b1);
        check_eq("stall_cnt2", 64'(RvviStall), 64'd0);
        send_pkt(12'd2, 1'b1);
        check_eq("stall_cnt3", 64'(RvviStall), 64'd1);
        send_pkt(12'd3, 1'b1);
        check_eq("stall_cnt4", 64'(RvviStall), 64'd1);
        check_eq("ovf_before", 64'(Overflow), 64'd0);
        send_pkt(12'd4, 1'b0);
        check_eq("ovf_set", 64'(Overflow), 64'd1);
        check_eq("count_full", 64'(dut.count_q), 64'd4);
        ClearOverflow = 1'b1;
        @(posedge clk);
        #1 ClearOverflow = 1'b0;
        check_eq("ovf_clear", 64'(Overflow), 64'd0);
        ClearOverflow = 1'b1;
        send_pkt(12'd5, 1'b0);
        ClearOverflow = 1'b0;
        check_eq("ovf_set_wins", 64'(Overflow), 64'd1);
        ClearOverflow = 1'b1;
        @(posedge clk);
        #1 ClearOverflow = 1'b0;
        check_eq("ovf_clear2", 64'(Overflow), 64'd0);
        Enable = 1'b0;
        #1;
        check_eq("stall_disabled", 64'(RvviStall), 64'd0);
        send_pkt(12'd1, 1'b0);
        check_eq("ovf_disabled", 64'(Overflow), 64'd0);
        check_eq("count_disabled", 64'(dut.count_q), 64'd4);
        Enable = 1'b1;
        #1;
        check_eq("stall_reenable", 64'(RvviStall), 64'd1);

        // Random TxReady drain of the four held packets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1 TxReady = 1'($urandom_range(0, 1));
            if (exp_q.size() == 0 && !TxValid) break;
        end
        TxReady = 1'b1;
        wait_drain(50);
        check_eq("count_drained", 64'(dut.count_q), 64'd0);

        // Write on the same edge as the final-word handshake with count=2.
        TxReady = 1'b0;
        send_pkt(12'd0, 1'b1);
        send_pkt(12'd1, 1'b1);
        TxReady = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (TxValid && TxLast && TxReady) begin
                found = 1'b1;
                check_eq("wp_count_before", 64'(dut.count_q), 64'd2);
                send_pkt(12'd2, 1'b1);
                check_eq("wp_count_after", 64'(dut.count_q), 64'd2);
                break;
            end
        end
        check_eq("wp_found", 64'(found), 64'd1);
        wait_drain(200);

        // Asynchronous reset while data word 7 is presented.
        send_pkt(12'd0, 1'b1);
        p_a = last_w;
        send_pkt(12'd1, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (rx_cnt == 8) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("rst_found", 64'(found), 64'd1);
        @(posedge clk);
        #2;
        check_eq("w7_valid", 64'(TxValid), 64'd1);
        check_eq("w7_data", 64'(TxData), 64'(p_a[7*32 +: 32]));
        reset = 1'b1;
        #1;
        check_eq("arst_txvalid", 64'(TxValid), 64'd0);
        check_eq("arst_count", 64'(dut.count_q), 64'd0);
        exp_q.delete();
        expl_q.delete();
        exp_seq = 8'd0;
        rx_cnt  = 0;
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        send_pkt(12'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_eq("hdr_after_rst", 64'(TxData), 64'h0000000D);
        wait_drain(100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
